// File: rtl/rpm_error_calc.sv
// rpm_error_calc: x4 quadrature decoder, windowed edge counter, RPM scaling and
// signed-magnitude error term (SETPOINT - measured) for the wheel PI loop.
// Also produces the PI prescaler clock, phased half a window after the update.
module rpm_error_calc #(
   parameter int          N_WIDTH       = 17,
   parameter int          Q_WIDTH       = 8,
   parameter int          CNT_WIDTH     = 16,
   parameter int          WINDOW_CYCLES = 4100,
   parameter logic [15:0] RPM_SCALE     = 16'h0100
) (
   input  logic               CLOCK_50,
   input  logic               RESET_n,
   input  logic               ENC_A,
   input  logic               ENC_B,
   input  logic [N_WIDTH-1:0] SETPOINT,
   output logic [N_WIDTH-1:0] ERROR_K,
   output logic [N_WIDTH-1:0] MEAS_RPM,
   output logic               ERROR_VALID,
   output logic               PRESCALER_CLK,
   output logic               ENC_ERR
);

   localparam int MW   = N_WIDTH - 1;                       // magnitude width
   localparam int EW   = N_WIDTH + 1;                       // two's-complement error width
   localparam int WW   = $clog2(WINDOW_CYCLES);
   localparam int QEXT = (Q_WIDTH > 8) ? Q_WIDTH - 8 : 0;   // RPM_SCALE is Q8
   localparam int QTRN = (Q_WIDTH < 8) ? 8 - Q_WIDTH : 0;
   localparam int PW   = CNT_WIDTH + 16 + QEXT;             // scaled product width

   localparam logic [MW-1:0]               MAG_MAX = '1;
   localparam logic signed [CNT_WIDTH:0]   SUM_MAX = {2'b00, {(CNT_WIDTH-1){1'b1}}};
   localparam logic signed [CNT_WIDTH:0]   SUM_MIN = -SUM_MAX;
   localparam logic [WW-1:0]               WIN_LAST = WW'(WINDOW_CYCLES - 1);
   localparam logic [WW-1:0]               WIN_HALF = WW'(WINDOW_CYCLES / 2);

   typedef enum logic [1:0] {
      S_COUNT = 2'd0,
      S_SCALE = 2'd1,
      S_ERROR = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Encoder synchronisers and previous-sample register
   // ------------------------------------------------------------------
   logic [1:0] a_sync_q, b_sync_q;
   logic [1:0] ab_prev_q;
   logic [1:0] ab_cur;

   assign ab_cur = {a_sync_q[1], b_sync_q[1]};

   // two-flop synchronisers plus a third flop holding the previous {A,B}
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         a_sync_q  <= '0;
         b_sync_q  <= '0;
         ab_prev_q <= '0;
      end else begin
         a_sync_q  <= {a_sync_q[0], ENC_A};
         b_sync_q  <= {b_sync_q[0], ENC_B};
         ab_prev_q <= ab_cur;
      end
   end

   // ------------------------------------------------------------------
   // x4 Gray decode: forward 00->01->11->10->00, double change is illegal
   // ------------------------------------------------------------------
   logic signed [1:0] step;
   logic              illegal;

   // map previous/current sample pair to a signed step
   always_comb begin
      step    = 2'sd0;
      illegal = 1'b0;
      case ({ab_prev_q, ab_cur})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step    = 2'sd1;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step    = -2'sd1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Window timer, saturating edge counter and snapshot
   // ------------------------------------------------------------------
   logic [WW-1:0]               win_q, win_d;
   logic                        win_end;
   logic signed [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_sat;
   logic signed [CNT_WIDTH-1:0] snap_q, snap_d;
   logic signed [CNT_WIDTH:0]   cnt_sum;
   logic                        presc_q, enc_err_q;

   assign win_end = (win_q == WIN_LAST);

   // next window position, count and snapshot; the terminal-cycle step is
   // folded into the snapshot so no edge is lost at the window boundary
   always_comb begin
      win_d   = win_end ? '0 : win_q + 1'b1;
      cnt_sum = $signed({cnt_q[CNT_WIDTH-1], cnt_q})
              + $signed({{(CNT_WIDTH-1){step[1]}}, step});
      if (cnt_sum > SUM_MAX)
         cnt_sat = SUM_MAX[CNT_WIDTH-1:0];
      else if (cnt_sum < SUM_MIN)
         cnt_sat = SUM_MIN[CNT_WIDTH-1:0];
      else
         cnt_sat = cnt_sum[CNT_WIDTH-1:0];
      cnt_d  = win_end ? '0 : cnt_sat;
      snap_d = win_end ? cnt_sat : snap_q;
   end

   // window, counter, snapshot, prescaler and sticky encoder-error state
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         win_q     <= '0;
         cnt_q     <= '0;
         snap_q    <= '0;
         presc_q   <= 1'b0;
         enc_err_q <= 1'b0;
      end else begin
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         // registered from the next window position so it tracks win_q exactly
         presc_q   <= (win_d >= WIN_HALF);
         enc_err_q <= enc_err_q | illegal;
      end
   end

   // ------------------------------------------------------------------
   // Sequencing FSM
   // ------------------------------------------------------------------
   state_t state_q, state_d;
   logic   load_meas, load_out;

   // state register
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) state_q <= S_COUNT;
      else          state_q <= state_d;
   end

   // next state and per-state load strobes
   always_comb begin
      state_d   = state_q;
      load_meas = 1'b0;
      load_out  = 1'b0;
      case (state_q)
         S_COUNT: if (win_end) state_d = S_SCALE;
         S_SCALE: begin
            load_meas = 1'b1;
            state_d   = S_ERROR;
         end
         S_ERROR: begin
            load_out = 1'b1;
            state_d  = S_OUT;
         end
         S_OUT:   state_d = S_COUNT;
         default: state_d = S_COUNT;
      endcase
   end

   // ------------------------------------------------------------------
   // Scaling: |snapshot| * RPM_SCALE, realigned to Q_WIDTH, saturated
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] snap_abs;
   logic [PW-1:0]        prod;
   logic [MW-1:0]        meas_mag;
   logic                 meas_sign;
   logic [N_WIDTH-1:0]   meas_q;

   // magnitude product and sign; zero magnitude always reported as +0
   always_comb begin
      snap_abs  = snap_q[CNT_WIDTH-1] ? (~snap_q + 1'b1) : snap_q;
      prod      = ((PW'(snap_abs) * PW'(RPM_SCALE)) << QEXT) >> QTRN;
      meas_mag  = (prod > PW'(MAG_MAX)) ? MAG_MAX : prod[MW-1:0];
      meas_sign = snap_q[CNT_WIDTH-1] && (meas_mag != '0);
   end

   // ------------------------------------------------------------------
   // Error: signed-magnitude -> two's complement, subtract, convert back
   // ------------------------------------------------------------------
   logic [EW-1:0] sp_tc, ms_tc, diff, diff_abs;
   logic [MW-1:0] err_mag;
   logic          err_sign;

   // SETPOINT is read here, i.e. only in the S_ERROR cycle; -0 becomes 0
   always_comb begin
      sp_tc    = SETPOINT[MW] ? -EW'(SETPOINT[MW-1:0]) : EW'(SETPOINT[MW-1:0]);
      ms_tc    = meas_q[MW]   ? -EW'(meas_q[MW-1:0])   : EW'(meas_q[MW-1:0]);
      diff     = sp_tc - ms_tc;
      diff_abs = diff[EW-1] ? (~diff + 1'b1) : diff;
      err_mag  = (diff_abs > EW'(MAG_MAX)) ? MAG_MAX : diff_abs[MW-1:0];
      err_sign = diff[EW-1] && (err_mag != '0);
   end

   // ------------------------------------------------------------------
   // Result registers
   // ------------------------------------------------------------------
   logic [N_WIDTH-1:0] err_out_q, meas_out_q;
   logic               valid_q;

   // measured value held between SCALE and ERROR; outputs and the valid
   // pulse update together so the S_OUT cycle shows the new values
   always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         meas_q     <= '0;
         err_out_q  <= '0;
         meas_out_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         if (load_meas) meas_q <= {meas_sign, meas_mag};
         if (load_out) begin
            err_out_q  <= {err_sign, err_mag};
            meas_out_q <= meas_q;
         end
         valid_q <= load_out;
      end
   end

   assign ERROR_K       = err_out_q;
   assign MEAS_RPM      = meas_out_q;
   assign ERROR_VALID   = valid_q;
   assign PRESCALER_CLK = presc_q;
   assign ENC_ERR       = enc_err_q;

endmodule
